// File: rtl/flex_pts_tx_pkg.sv
// Shared types and legality constants for the flex_pts_tx serial transmitter.
package flex_pts_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam int STOP_BITS_MIN  = 1;
  localparam int STOP_BITS_MAX  = 2;
  localparam int NUM_BITS_MIN   = 2;
  localparam int NUM_BITS_MAX   = 32;
  localparam int BIT_CYCLES_MIN = 1;
  localparam int BIT_CYCLES_MAX = 65535;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear, count enable and a programmable wrap value.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             rollover_flag
);

  // Flag marks the terminal value; the next enabled edge wraps to zero.
  assign rollover_flag = (count == rollover_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= rollover_flag ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial UART-style transmitter with a one-entry holding register.
// Handshake: a word moves on a rising edge where data_valid and data_ready are both 1.
module flex_pts_tx
  import flex_pts_tx_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int SHIFT_MSB  = 0,
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                serial_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int BIT_W = 16;
  localparam int IDX_W = 5;

  if (NUM_BITS < NUM_BITS_MIN || NUM_BITS > NUM_BITS_MAX) begin : g_bad_num_bits
    $error("flex_pts_tx: NUM_BITS out of range");
  end
  if (BIT_CYCLES < BIT_CYCLES_MIN || BIT_CYCLES > BIT_CYCLES_MAX) begin : g_bad_bit_cycles
    $error("flex_pts_tx: BIT_CYCLES out of range");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("flex_pts_tx: STOP_BITS must be 1 or 2");
  end

  state_t              state, state_n;
  logic [NUM_BITS-1:0] shift_q, shift_d, shifted, load_word, hold_q;
  logic                parity_q, parity_d;
  logic                hold_full, load, accept, ser_d;
  logic                bit_flag, idx_flag, bit_end, frame_end;
  logic [IDX_W-1:0]    idx_roll;
  logic [BIT_W-1:0]    unused_bit_cnt;
  logic [IDX_W-1:0]    unused_idx_cnt;

  assign busy       = (state != IDLE);
  assign data_ready = !hold_full;
  assign accept     = data_valid && data_ready;
  assign bit_end    = busy && bit_flag;
  assign frame_end  = (state == STOP) && bit_end && idx_flag;
  assign frame_done = frame_end;

  flex_counter #(.WIDTH(BIT_W)) u_bit_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (!busy),
    .count_en      (busy),
    .rollover_val  (BIT_W'(BIT_CYCLES - 1)),
    .count         (unused_bit_cnt),
    .rollover_flag (bit_flag)
  );

  // The index counter wraps to zero at the last data bit, so STOP starts from 0.
  always_comb begin
    idx_roll = '0;
    if (state == DATA)      idx_roll = IDX_W'(NUM_BITS - 1);
    else if (state == STOP) idx_roll = IDX_W'(STOP_BITS - 1);
  end

  flex_counter #(.WIDTH(IDX_W)) u_idx_cnt (
    .clk           (clk),
    .rst           (rst),
    .clear         (!busy),
    .count_en      (bit_end && (state == DATA || state == STOP)),
    .rollover_val  (idx_roll),
    .count         (unused_idx_cnt),
    .rollover_flag (idx_flag)
  );

  assign shifted = (SHIFT_MSB != 0) ? {shift_q[NUM_BITS-2:0], 1'b1}
                                    : {1'b1, shift_q[NUM_BITS-1:1]};

  always_comb begin
    state_n   = state;
    shift_d   = shift_q;
    parity_d  = parity_q;
    load      = 1'b0;
    load_word = data_in;
    ser_d     = 1'b1;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          load    = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shifted;
          if (idx_flag) state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
      STOP: begin
        if (frame_end) begin
          if (hold_full) begin
            state_n   = START;
            load      = 1'b1;
            load_word = hold_q;
          end else if (data_valid) begin
            state_n = START;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      shift_d  = load_word;
      parity_d = (^load_word) ^ (PARITY_ODD != 0);
    end
    // serial_out is registered from the next state so it lines up with state.
    case (state_n)
      START:   ser_d = 1'b0;
      DATA:    ser_d = (SHIFT_MSB != 0) ? shift_d[NUM_BITS-1] : shift_d[0];
      PARITY:  ser_d = parity_d;
      default: ser_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '1;
      parity_q   <= 1'b0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_n;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      serial_out <= ser_d;
    end
  end

  // Words accepted mid-frame wait here; a frame-end accept goes straight to the shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_q    <= '0;
    end else if (accept && busy && !frame_end) begin
      hold_full <= 1'b1;
      hold_q    <= data_in;
    end else if (frame_end && hold_full) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flex_pts_tx.sv
// Directed bench for flex_pts_tx: three parameter sets, a frame table and multi-cycle sequences.
module tb_flex_pts_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       dr  [3];
  logic       so  [3];
  logic       bz  [3];
  logic       fd  [3];

  always #5 clk = ~clk;

  flex_pts_tx u_def (
    .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(dr[0]), .serial_out(so[0]), .busy(bz[0]), .frame_done(fd[0])
  );

  flex_pts_tx #(.SHIFT_MSB(1), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(dr[1]), .serial_out(so[1]), .busy(bz[1]), .frame_done(fd[1])
  );

  flex_pts_tx #(.BIT_CYCLES(1), .STOP_BITS(2)) u_edge (
    .clk(clk), .rst(rst), .data_in(din[2]), .data_valid(dv[2]),
    .data_ready(dr[2]), .serial_out(so[2]), .busy(bz[2]), .frame_done(fd[2])
  );

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [15:0] exp_bits;  // bit 0 is the first bit on the line
    int          nbits;
    int          bc;
  } vec_t;

  vec_t vecs [10];
  int   n_vec = 0;
  int   n_bad = 0;
  int   waited;

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input int sel, input logic [7:0] data, input string name);
    chk({name, " idle"}, bz[sel], 1'b0);
    chk({name, " ready"}, dr[sel], 1'b1);
    din[sel] = data;
    dv[sel]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dv[sel]  = 1'b0;
  endtask

  // Starts at the negedge of the first frame clock, ends at the negedge after the last.
  task automatic check_frame(input int sel, input logic [15:0] exp_bits, input int nbits,
                             input int bc, input string name);
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bc; c++) begin
        chk($sformatf("%s bit%0d clk%0d serial", name, b, c), so[sel], exp_bits[b]);
        chk($sformatf("%s bit%0d clk%0d busy", name, b, c), bz[sel], 1'b1);
        chk($sformatf("%s bit%0d clk%0d done", name, b, c), fd[sel],
            (b == nbits - 1) && (c == bc - 1));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    vecs[0] = '{0, 8'hA5, 16'(10'b1_10100101_0),   10, 4};
    vecs[1] = '{0, 8'h00, 16'(10'b1_00000000_0),   10, 4};
    vecs[2] = '{0, 8'hFF, 16'(10'b1_11111111_0),   10, 4};
    vecs[3] = '{0, 8'h3C, 16'(10'b1_00111100_0),   10, 4};
    vecs[4] = '{1, 8'hA5, 16'(11'b1_0_10100101_0), 11, 4};
    vecs[5] = '{1, 8'h01, 16'(11'b1_1_10000000_0), 11, 4};
    vecs[6] = '{1, 8'h03, 16'(11'b1_0_11000000_0), 11, 4};
    vecs[7] = '{2, 8'h00, 16'(11'b11_00000000_0),  11, 1};
    vecs[8] = '{2, 8'hA5, 16'(11'b11_10100101_0),  11, 1};
    vecs[9] = '{2, 8'h80, 16'(11'b11_10000000_0),  11, 1};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      din[s] = 8'h00;
      dv[s]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset%0d serial", s), so[s], 1'b1);
      chk($sformatf("reset%0d busy", s), bz[s], 1'b0);
      chk($sformatf("reset%0d done", s), fd[s], 1'b0);
      chk($sformatf("reset%0d ready", s), dr[s], 1'b1);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive_start(vecs[i].sel, vecs[i].data, $sformatf("v%0d", i));
      check_frame(vecs[i].sel, vecs[i].exp_bits, vecs[i].nbits, vecs[i].bc,
                  $sformatf("v%0d", i));
    end

    // Back-to-back: second word lands in the holding register one clock later.
    drive_start(0, 8'h01, "b2b");
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    fork
      check_frame(0, 16'(10'b1_00000001_0), 10, 4, "b2b first");
      begin
        @(negedge clk);
        dv[0] = 1'b0;
        chk("b2b ready low", dr[0], 1'b0);
      end
    join
    check_frame(0, 16'(10'b1_11111111_0), 10, 4, "b2b second");
    chk("b2b idle after", bz[0], 1'b0);

    // Backpressure: third word waits for the holding register to drain.
    drive_start(0, 8'h11, "bp");
    din[0] = 8'h22;
    dv[0]  = 1'b1;
    fork
      begin
        check_frame(0, 16'(10'b1_00010001_0), 10, 4, "bp w1");
        check_frame(0, 16'(10'b1_00100010_0), 10, 4, "bp w2");
        check_frame(0, 16'(10'b1_00110011_0), 10, 4, "bp w3");
      end
      begin
        waited = 0;
        @(negedge clk);
        din[0] = 8'h33;
        while (!dr[0] && waited < 100) begin
          @(negedge clk);
          waited++;
        end
        chk_int("bp third word wait", waited, 39);
        @(negedge clk);
        dv[0] = 1'b0;
      end
    join
    chk("bp idle after", bz[0], 1'b0);

    // Word presented on the last stop clock goes straight out, no idle gap.
    drive_start(2, 8'h00, "chain");
    fork
      check_frame(2, 16'(11'b11_00000000_0), 11, 1, "chain first");
      begin
        repeat (10) @(negedge clk);
        chk("chain ready at end", dr[2], 1'b1);
        din[2] = 8'h0F;
        dv[2]  = 1'b1;
        @(negedge clk);
        dv[2]  = 1'b0;
      end
    join
    check_frame(2, 16'(11'b11_00001111_0), 11, 1, "chain second");
    chk("chain idle after", bz[2], 1'b0);

    // Reset at clock 17 of a frame with the holding register full.
    drive_start(0, 8'h55, "rst");
    din[0] = 8'h66;
    dv[0]  = 1'b1;
    @(negedge clk);
    dv[0]  = 1'b0;
    chk("rst hold full", dr[0], 1'b0);
    repeat (15) @(negedge clk);
    chk("rst pre serial", so[0], 1'b0);
    rst = 1'b1;
    #1;
    chk("rst serial", so[0], 1'b1);
    chk("rst busy", bz[0], 1'b0);
    chk("rst ready", dr[0], 1'b1);
    chk("rst done", fd[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_start(0, 8'h3C, "post rst");
    check_frame(0, 16'(10'b1_00111100_0), 10, 4, "post rst");
    repeat (3) begin
      chk("post rst no stale", bz[0], 1'b0);
      chk("post rst line idle", so[0], 1'b1);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
